stream_rr_mux: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes, round-robin arbitration, optional packet locking and a registered output stage. It is the next-generation replacement for the fixed 2-bit, 2-input select mux. Channel choice is no longer an external select: an internal arbiter grants among requesting channels. The block sits between several producer streams and one consumer stream.

---
 rtl/stream_rr_mux.sv | 125 ++++++++++++
 tb/tb_stream_rr_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_mux.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration,
// optional packet locking and a registered (skid-free pipe) output stage.
module stream_rr_mux #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int PKT_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH*WIDTH-1:0]     in_data,
  input  logic [N_CH-1:0]           in_last,
  output logic [N_CH-1:0]           in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [$clog2(N_CH)-1:0]   out_sel,
  input  logic                      out_ready
);

  localparam int SW = $clog2(N_CH);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state, state_next;
  logic [SW-1:0]     lock_ch, lock_ch_next;
  logic [SW-1:0]     ptr;
  logic [N_CH-1:0]   rr_grant;
  logic [SW-1:0]     rr_idx;
  logic [N_CH-1:0]   grant;
  logic [SW-1:0]     g;
  logic              can_load;
  logic              accept;
  logic              acc_last;
  logic [WIDTH-1:0]  ch_data [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search starting at ptr, wrapping past N_CH-1 back to 0.
  always_comb begin
    logic found;
    rr_grant = '0;
    rr_idx   = '0;
    found    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      automatic logic [SW:0] pos = {1'b0, ptr} + (SW+1)'(i);
      if (pos >= (SW+1)'(N_CH)) pos = pos - (SW+1)'(N_CH);
      if (!found && in_valid[pos[SW-1:0]]) begin
        found                 = 1'b1;
        rr_grant[pos[SW-1:0]] = 1'b1;
        rr_idx                = pos[SW-1:0];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_next;
      lock_ch <= lock_ch_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next   = state;
    lock_ch_next = lock_ch;
    if (PKT_MODE != 0 && accept) begin
      if (state == IDLE && !acc_last) begin
        state_next   = LOCKED;
        lock_ch_next = g;
      end else if (state == LOCKED && acc_last) begin
        state_next = IDLE;
      end
    end
  end

  // FSM: outputs -- a locked channel keeps the grant even while it is idle
  always_comb begin
    grant = '0;
    g     = '0;
    if (state == LOCKED) begin
      grant[lock_ch] = 1'b1;
      g              = lock_ch;
    end else begin
      grant = rr_grant;
      g     = rr_idx;
    end
  end

  assign can_load = !out_valid || out_ready;
  assign in_ready = grant & {N_CH{can_load && rst_n}};
  assign accept   = |(in_ready & in_valid);
  assign acc_last = in_last[g];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && (PKT_MODE == 0 || acc_last)) begin
      ptr <= (g == SW'(N_CH-1)) ? '0 : g + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[g];
      out_last  <= acc_last;
      out_sel   <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed bench: a packet-mode and a beat-mode instance share one set of
// producer/consumer stimulus; each scenario checks the relevant instance.
module tb_stream_rr_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  p_ready, b_ready;
  logic        p_ov, b_ov, p_last, b_last;
  logic [7:0]  p_data, b_data;
  logic [1:0]  p_sel, b_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_rr_mux #(.N_CH(4), .WIDTH(8), .PKT_MODE(1)) dut_pkt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(p_ready), .out_valid(p_ov), .out_data(p_data),
    .out_last(p_last), .out_sel(p_sel), .out_ready(out_ready)
  );

  stream_rr_mux #(.N_CH(4), .WIDTH(8), .PKT_MODE(0)) dut_beat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_ready), .out_valid(b_ov), .out_data(b_data),
    .out_last(b_last), .out_sel(b_sel), .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       oready;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic       exp_last;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_p(input string name, input logic ov, input logic lst,
                       input logic [1:0] sel, input logic [7:0] dat);
    chk(name, {20'h0, p_ov, p_last, p_sel, p_data}, {20'h0, ov, lst, sel, dat});
    $display("pkt  %s: valid=%0b last=%0b sel=%0d data=%02h", name, p_ov, p_last, p_sel, p_data);
  endtask

  task automatic chk_b(input string name, input logic ov, input logic lst,
                       input logic [1:0] sel, input logic [7:0] dat);
    chk(name, {20'h0, b_ov, b_last, b_sel, b_data}, {20'h0, ov, lst, sel, dat});
    $display("beat %s: valid=%0b last=%0b sel=%0d data=%02h", name, b_ov, b_last, b_sel, b_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    in_data[ch*8 +: 8] = v;
  endtask

  task automatic default_data();
    in_data = 32'h13121110;
  endtask

  task automatic do_reset();
    in_valid  = 4'b0000;
    in_last   = 4'b0000;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with every producer requesting
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    default_data();
    tick();
    tick();
    chk("rst_p_ready", {28'h0, p_ready}, 32'h0);
    chk("rst_b_ready", {28'h0, b_ready}, 32'h0);
    chk_p("rst_p_out", 1'b0, 1'b0, 2'd0, 8'h00);
    chk_b("rst_b_out", 1'b0, 1'b0, 2'd0, 8'h00);
    rst_n = 1'b1;
    #1 chk("rel_p_ready", {28'h0, p_ready}, 32'h1);
    tick();
    chk_p("rel_first", 1'b1, 1'b1, 2'd0, 8'h10);

    // Beat mode table: fairness, wrap-around, idle, back-pressure
    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h11};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h12};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h13};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10};
    vecs[5]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd3, 8'h13};
    vecs[6]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h11};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h11};
    vecs[8]  = '{4'b0011, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10};
    vecs[9]  = '{4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h10};
    vecs[10] = '{4'b0011, 4'b0001, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 8'h11};

    do_reset();
    default_data();
    for (int i = 0; i < 11; i++) begin
      in_valid  = vecs[i].valid;
      in_last   = vecs[i].last;
      out_ready = vecs[i].oready;
      #1 chk($sformatf("vec%0d_ready", i), {28'h0, b_ready}, {28'h0, vecs[i].exp_ready});
      tick();
      chk_b($sformatf("vec%0d_out", i), vecs[i].exp_ov, vecs[i].exp_last,
            vecs[i].exp_sel, vecs[i].exp_data);
    end

    // Packet lock: channel 1 sends A1..A3 while channel 2 waits
    do_reset();
    in_valid = 4'b0110;
    in_last  = 4'b0100;
    set_data(1, 8'hA1);
    set_data(2, 8'h20);
    #1 chk("lock_a1_ready", {28'h0, p_ready}, 32'b0010);
    tick();
    chk_p("lock_a1", 1'b1, 1'b0, 2'd1, 8'hA1);
    set_data(1, 8'hA2);
    #1 chk("lock_a2_ready", {28'h0, p_ready}, 32'b0010);
    tick();
    chk_p("lock_a2", 1'b1, 1'b0, 2'd1, 8'hA2);
    set_data(1, 8'hA3);
    in_last = 4'b0110;
    #1 chk("lock_a3_ready", {28'h0, p_ready}, 32'b0010);
    tick();
    chk_p("lock_a3", 1'b1, 1'b1, 2'd1, 8'hA3);
    in_valid = 4'b0100;
    #1 chk("lock_ch2_ready", {28'h0, p_ready}, 32'b0100);
    tick();
    chk_p("lock_ch2", 1'b1, 1'b1, 2'd2, 8'h20);

    // Lock with a two-cycle gap on channel 1 while channel 0 requests
    do_reset();
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    set_data(1, 8'hB1);
    set_data(0, 8'h30);
    #1 chk("gap_b1_ready", {28'h0, p_ready}, 32'b0010);
    tick();
    chk_p("gap_b1", 1'b1, 1'b0, 2'd1, 8'hB1);
    in_valid = 4'b0001;
    in_last  = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("gap%0d_ready", i), {28'h0, p_ready}, 32'b0010);
      tick();
      chk_p($sformatf("gap%0d_out", i), 1'b0, 1'b0, 2'd1, 8'hB1);
    end
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    set_data(1, 8'hB2);
    #1 chk("gap_b2_ready", {28'h0, p_ready}, 32'b0010);
    tick();
    chk_p("gap_b2", 1'b1, 1'b1, 2'd1, 8'hB2);
    in_valid = 4'b0001;
    #1 chk("gap_ch0_ready", {28'h0, p_ready}, 32'b0001);
    tick();
    chk_p("gap_ch0", 1'b1, 1'b1, 2'd0, 8'h30);

    // Back-pressure: five stalled cycles, then the waiting beat follows
    do_reset();
    in_valid = 4'b0001;
    in_last  = 4'b0001;
    set_data(0, 8'h40);
    set_data(2, 8'h50);
    #1 chk("bp_first_ready", {28'h0, p_ready}, 32'b0001);
    tick();
    chk_p("bp_first", 1'b1, 1'b1, 2'd0, 8'h40);
    in_valid  = 4'b0100;
    in_last   = 4'b0100;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("bp%0d_ready", i), {28'h0, p_ready}, 32'h0);
      tick();
      chk_p($sformatf("bp%0d_hold", i), 1'b1, 1'b1, 2'd0, 8'h40);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_ready", {28'h0, p_ready}, 32'b0100);
    tick();
    chk_p("bp_rel", 1'b1, 1'b1, 2'd2, 8'h50);

    // Reset while locked on channel 3, then everyone requests
    do_reset();
    in_valid = 4'b1000;
    in_last  = 4'b0000;
    set_data(3, 8'h60);
    #1 chk("mid_ch3_ready", {28'h0, p_ready}, 32'b1000);
    tick();
    chk_p("mid_ch3", 1'b1, 1'b0, 2'd3, 8'h60);
    #2 rst_n = 1'b0;
    #1 chk_p("mid_rst_out", 1'b0, 1'b0, 2'd0, 8'h00);
    chk("mid_rst_ready", {28'h0, p_ready}, 32'h0);
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    default_data();
    tick();
    rst_n = 1'b1;
    #1 chk("mid_rel_ready", {28'h0, p_ready}, 32'b0001);
    tick();
    chk_p("mid_rel", 1'b1, 1'b1, 2'd0, 8'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
